// File: rtl/program_loader.sv
// ============================================================================
// program_loader: streams host bytes into big-endian words in instruction memory, then pulses start.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic             abort,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      i_addr,
  output logic [31:0]      instruction,
  output logic             i_enable,
  output logic             i_write,
  output logic             program_load,
  output logic             start,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      shift_q, shift_d;
  logic [CNT_W-1:0] length_q, length_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [31:0]      i_addr_q, i_addr_d;
  logic [31:0]      instruction_q, instruction_d;

  logic             accept;
  logic [31:0]      assembled;
  logic [CNT_W-1:0] wc_next;

  assign in_ready  = (state_q == S_LEN) || (state_q == S_DATA);
  assign accept    = in_valid && in_ready;
  assign assembled = {shift_q, in_data};
  assign wc_next   = word_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d       = state_q;
    byte_idx_d    = byte_idx_q;
    shift_d       = shift_q;
    length_d      = length_q;
    word_count_d  = word_count_q;
    i_addr_d      = i_addr_q;
    instruction_d = instruction_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (load_req) begin
          state_d      = S_LEN;
          word_count_d = '0;
          byte_idx_d   = 2'd0;
        end
      end
      S_LEN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          shift_d    = assembled[23:0];
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (assembled == 32'd0) begin
              state_d = S_DONE;
            end else if (assembled > 32'(MAX_WORDS)) begin
              state_d = S_ERR;
            end else begin
              length_d = assembled[CNT_W-1:0];
              state_d  = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          shift_d    = assembled[23:0];
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Address is latched here so it holds steady through and after WRITE.
            instruction_d = assembled;
            i_addr_d      = BASE_ADDR + (32'(word_count_q) << 2);
            state_d       = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        // The strobe is already out this cycle, so the word counts even on abort.
        word_count_d = wc_next;
        if (abort) begin
          state_d = S_IDLE;
        end else if (wc_next == length_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      byte_idx_q    <= 2'd0;
      shift_q       <= '0;
      length_q      <= '0;
      word_count_q  <= '0;
      i_addr_q      <= '0;
      instruction_q <= '0;
    end else begin
      state_q       <= state_d;
      byte_idx_q    <= byte_idx_d;
      shift_q       <= shift_d;
      length_q      <= length_d;
      word_count_q  <= word_count_d;
      i_addr_q      <= i_addr_d;
      instruction_q <= instruction_d;
    end
  end

  assign i_addr       = i_addr_q;
  assign instruction  = instruction_q;
  assign i_enable     = (state_q == S_WRITE);
  assign i_write      = (state_q == S_WRITE);
  assign program_load = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
  assign start        = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE) && (state_q != S_ERR);
  assign error        = (state_q == S_ERR);
  assign word_count   = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader: scoreboard bench for program_loader (MAX_WORDS=4).
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_program_loader;

  localparam int MAXW  = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset, load_req, abort, in_valid;
  logic [7:0]       in_data;
  logic             in_ready, i_enable, i_write, program_load, start, busy, error;
  logic [31:0]      i_addr, instruction;
  logic [CNT_W-1:0] word_count;
  logic [86:0]      all_out;

  program_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .i_addr(i_addr), .instruction(instruction), .i_enable(i_enable),
    .i_write(i_write), .program_load(program_load), .start(start),
    .busy(busy), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  assign all_out = {in_ready, i_addr, instruction, i_enable, i_write,
                    program_load, start, busy, error, word_count};

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         sb[$];
  wr_t         mon_e;
  logic [31:0] prog [4];
  int n_vec = 0, n_err = 0, n_write = 0, n_start = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (i_write) begin
      n_write++;
      if (sb.size() == 0) begin
        check_val("unexpected_write", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("wr_addr", i_addr, mon_e.addr);
        check_val("wr_data", instruction, mon_e.data);
      end
      check_val("ready_in_write", in_ready, 0);
      check_val("pl_in_write", program_load, 1);
      check_val("en_in_write", i_enable, 1);
    end
    if (start) n_start++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit gaps, input bit force_first);
    bit acc   = 1'b0;
    bit first = 1'b1;
    int guard = 0;
    in_data = b;
    while (!acc) begin
      in_valid = !(gaps && !(force_first && first) && ($urandom_range(0, 2) == 0));
      first = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) check_val("pl_accept", program_load, 1);
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 100) begin
        check_val("hs_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) push_byte(w[8*i +: 8], gaps, i == 3);
  endtask

  task automatic run_load(input logic [31:0] len, input int nsend, input bit gaps);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    push_word(len, gaps);
    for (int i = 0; i < nsend; i++) begin
      sb.push_back('{addr: 32'(4 * i), data: prog[i]});
      push_word(prog[i], gaps);
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_finish(input int nwords, input int exp_wc);
    int s0 = n_start;
    if (nwords > 0) begin
      @(negedge clk);
      check_val("last_write", i_write, 1);
    end
    @(negedge clk);
    check_val("start_pulse", start, 1);
    check_val("pl_in_done", program_load, 0);
    check_val("no_write_done", i_write, 0);
    @(negedge clk);
    check_val("start_width", start, 0);
    check_val("idle_busy", busy, 0);
    check_val("word_count", word_count, exp_wc);
    check_val("start_count", n_start - s0, 1);
  endtask

  task automatic set_prog2();
    prog[0] = 32'h3C01_1234;
    prog[1] = 32'hAC22_0008;
  endtask

  task automatic full_load(input bit gaps);
    int w0 = n_write;
    set_prog2();
    run_load(32'd2, 2, gaps);
    expect_finish(2, 2);
    check_val("write_count", n_write - w0, 2);
    check_val("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int s0, w0;
    reset = 1'b1; load_req = 1'b0; abort = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    // 1. reset with valid data presented
    @(posedge clk);
    @(negedge clk);
    check_val("reset_outs_c1", all_out, 0);
    @(negedge clk);
    check_val("reset_outs_c2", all_out, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("idle_outs", all_out, 0);
    in_valid = 1'b0;
    tick();

    // 2. two-word load, valid held high
    full_load(1'b0);
    // 3. random gaps, byte presented during WRITE
    full_load(1'b1);

    // 4. zero length
    w0 = n_write;
    run_load(32'd0, 0, 1'b0);
    expect_finish(0, 0);
    check_val("zero_no_write", n_write - w0, 0);

    // 5. over-length, then recovery
    s0 = n_start; w0 = n_write;
    run_load(32'd5, 0, 1'b0);
    @(negedge clk);
    check_val("err_flag", error, 1);
    check_val("err_ready", in_ready, 0);
    check_val("err_busy", busy, 0);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (5) tick();
    check_val("err_held", error, 1);
    check_val("err_no_write", n_write - w0, 0);
    check_val("err_no_start", n_start - s0, 0);
    in_valid = 1'b0;
    prog[0] = 32'hDEAD_BEEF;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check_val("err_cleared", error, 0);
    push_word(32'd1, 1'b0);
    sb.push_back('{addr: 32'h0, data: prog[0]});
    push_word(prog[0], 1'b0);
    in_valid = 1'b0;
    expect_finish(1, 1);

    // 6A. reset after the first word
    s0 = n_start;
    prog[0] = 32'h1111_1111;
    run_load(32'd2, 1, 1'b0);
    @(negedge clk);
    check_val("a_first_write", i_write, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_val("a_outs_zero", all_out, 0);
    repeat (4) tick();
    check_val("a_no_start", n_start - s0, 0);
    full_load(1'b0);

    // 6B. abort after the first word
    s0 = n_start;
    prog[0] = 32'h2222_2222;
    run_load(32'd2, 1, 1'b0);
    @(negedge clk);
    check_val("b_first_write", i_write, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check_val("b_busy", busy, 0);
    check_val("b_word_count", word_count, 1);
    check_val("b_pl", program_load, 0);
    repeat (4) tick();
    check_val("b_no_start", n_start - s0, 0);
    full_load(1'b0);

    check_val("sb_final", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
